mul_accumulator: RTL and testbench



---
 rtl/mul_acc_pkg.sv | 20 ++
 rtl/mul_acc_add_ovf.sv | 26 ++
 rtl/mul_accumulator.sv | 131 +++++++++++++
 tb/tb_mul_accumulator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared definitions for the burst multiply-accumulator.
// Provides the accumulator width derivation, the FSM state type and
// the term-counter width.
package mul_acc_pkg;

    // Term counter width; the counter saturates at its all-ones value.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ACC  = 1'b0,   // accepting burst terms
        HOLD = 1'b1    // presenting a finished result
    } state_e;

    // Products are 2n bits wide; g guard bits absorb growth over a burst.
    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

endpackage

// File: rtl/mul_acc_add_ovf.sv
// Accumulator adder with overflow detection for signed or unsigned terms.
// Ports: acc_i (current sum), term_i (extended term), signed_i (burst mode),
//        sum_o (wrapped sum), ovf_o (overflow of this single addition).
module acc_add_ovf #(
    parameter int W = 20
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] term_i,
    input  logic         signed_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] full_sum;
    logic       signed_ovf;

    // One extra bit captures the unsigned carry out of the top bit.
    assign full_sum = {1'b0, acc_i} + {1'b0, term_i};
    assign sum_o    = full_sum[W-1:0];

    // Two's-complement overflow: like-signed operands, differently-signed result.
    assign signed_ovf = (acc_i[W-1] == term_i[W-1]) && (sum_o[W-1] != acc_i[W-1]);

    assign ovf_o = signed_i ? signed_ovf : full_sum[W];

endmodule

// File: rtl/mul_accumulator.sv
// Burst accumulator: sums sign/zero-extended multiplier products per burst and
// presents the total with sticky overflow, signedness-mismatch and term count.
// Ports: in_* product handshake (valid/ready), clr abort, out_* result handshake.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int N = 8,
    parameter int G = 4,
    localparam int ACC_W = acc_width(N, G)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    input  logic               in_signed,
    input  logic               in_last,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic               out_ovf,
    output logic               out_err,
    output logic [CNT_W-1:0]   out_cnt
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               mode_q, mode_d;

    logic               first_term;
    logic               term_mode;
    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;

    // The first term of a burst defines its mode; later terms follow it even
    // when their own flag disagrees (the disagreement is reported via err).
    assign first_term = (cnt_q == '0);
    assign term_mode  = first_term ? in_signed : mode_q;
    assign term_ext   = term_mode ? {{G{in_prod[2*N-1]}}, in_prod}
                                  : {{G{1'b0}}, in_prod};

    acc_add_ovf #(
        .W(ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .term_i   (term_ext),
        .signed_i (term_mode),
        .sum_o    (add_sum),
        .ovf_o    (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        mode_d  = mode_q;

        if (clr) begin
            // Abort wins over any same-cycle transfer or result handshake.
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_ovf;
                        if (first_term) begin
                            mode_d = in_signed;
                        end else if (in_signed != mode_q) begin
                            err_d = 1'b1;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (in_last) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

    // Handshake flags decode the state register only; the result fields are
    // the accumulator registers themselves, frozen while in HOLD.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_err   = err_q;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_mul_accumulator.sv
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = '0;
    logic        in_signed = 1'b0;
    logic        in_last = 1'b0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_acc;
    logic        out_ovf;
    logic        out_err;
    logic [7:0]  out_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_accumulator #(.N(8), .G(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_signed (in_signed),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_err   (out_err),
        .out_cnt   (out_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: burst sum kept as a plain integer, checked against the
    // representable range of a 20-bit signed or unsigned value on every term.
    logic        m_hold = 1'b0;
    logic [19:0] m_sum  = '0;
    logic        m_ovf  = 1'b0;
    logic        m_err  = 1'b0;
    int          m_cnt  = 0;
    logic        m_mode = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic   t_mode;
        longint t_a, t_e, t_r;
        if (!rst_n) begin
            m_hold <= 1'b0; m_sum <= '0; m_ovf <= 1'b0; m_err <= 1'b0; m_cnt <= 0; m_mode <= 1'b0;
        end else if (clr) begin
            m_hold <= 1'b0; m_sum <= '0; m_ovf <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold <= 1'b0; m_sum <= '0; m_ovf <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
            end
        end else if (in_valid) begin
            t_mode = (m_cnt == 0) ? in_signed : m_mode;
            if (m_cnt == 0) m_mode <= in_signed;
            else if (in_signed != m_mode) m_err <= 1'b1;
            if (t_mode) begin
                t_a = longint'($signed(m_sum));
                t_e = longint'($signed(in_prod));
            end else begin
                t_a = longint'(m_sum);
                t_e = longint'(in_prod);
            end
            t_r = t_a + t_e;
            if (t_mode ? (t_r > 524287 || t_r < -524288) : (t_r > 1048575)) m_ovf <= 1'b1;
            m_sum <= t_r[19:0];
            m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            if (in_last) m_hold <= 1'b1;
        end
    end

    // Compare process: every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("m_in_ready", in_ready, !m_hold);
        chk("m_out_valid", out_valid, m_hold);
        if (m_hold && out_valid) begin
            chk("m_out_acc", out_acc, m_sum);
            chk("m_out_ovf", out_ovf, m_ovf);
            chk("m_out_err", out_err, m_err);
            chk("m_out_cnt", out_cnt, m_cnt);
        end
    end

    task automatic send(input logic [15:0] p, input logic s, input logic l);
        int b;
        @(negedge clk);
        b = 0;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        in_valid = 1'b1; in_prod = p; in_signed = s; in_last = l;
    endtask

    task automatic get_result(input logic [19:0] acc, input int cnt, input logic ovf,
                              input logic err, input int stall);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("lat_out_valid", out_valid, 1);
        chk("res_acc", out_acc, acc);
        chk("res_cnt", out_cnt, cnt);
        chk("res_ovf", out_ovf, ovf);
        chk("res_err", out_err, err);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("bp_acc", out_acc, acc);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
    endtask

    task automatic expect_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic burst_sgn;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_cnt", out_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Unsigned burst
        send(16'h0010, 0, 0); send(16'h0020, 0, 0); send(16'h0030, 0, 1);
        get_result(20'h00060, 3, 0, 0, 0);
        // Signed burst: -16 + 5 = -11
        send(16'hFFF0, 1, 0); send(16'h0005, 1, 1);
        get_result(20'hFFFF5, 2, 0, 0, 0);
        // Unsigned wrap
        for (int i = 0; i < 17; i++) send(16'hFFFF, 0, i == 16);
        get_result(20'h0FFEF, 17, 1, 0, 0);
        // Signed positive overflow
        for (int i = 0; i < 32; i++) send(16'h4000, 1, i == 31);
        get_result(20'h80000, 32, 1, 0, 0);
        // Backpressure, then a one-term burst
        send(16'h0123, 0, 1);
        get_result(20'h00123, 1, 0, 0, 5);
        send(16'h0001, 0, 1);
        get_result(20'h00001, 1, 0, 0, 0);
        // Signedness mismatch: second term zero-extended
        send(16'h0002, 0, 0); send(16'hFFFF, 1, 1);
        get_result(20'h10001, 2, 0, 1, 0);
        // Count saturation: sum keeps growing
        for (int i = 0; i < 300; i++) send(16'h0001, 0, i == 299);
        get_result(20'h0012C, 255, 0, 0, 0);
        // clr mid-burst, with a same-cycle last term that must be discarded
        send(16'h0002, 0, 0); send(16'h0003, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; in_prod = 16'h0007; in_last = 1'b1; clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
        expect_idle(3);
        send(16'h0005, 0, 1);
        get_result(20'h00005, 1, 0, 0, 0);
        // clr drops a held result
        send(16'h0009, 0, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_drop_valid", out_valid, 0);
        // Reset pulse mid-burst
        send(16'h0009, 0, 0); send(16'h0004, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle(3);
        send(16'h0001, 1, 1);
        get_result(20'h00001, 1, 0, 0, 0);

        // Randomized traffic against the model
        burst_sgn = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!(in_valid && !in_ready)) begin
                if ($urandom_range(0, 7) == 0) burst_sgn = ~burst_sgn;
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: in_prod = 16'($urandom);
                    1: in_prod = 16'hFFFF;
                    2: in_prod = 16'h8000 ^ 16'($urandom_range(0, 3));
                    default: in_prod = 16'($urandom_range(0, 255));
                endcase
                in_signed = burst_sgn ^ ($urandom_range(0, 15) == 0);
                in_last = ($urandom_range(0, 9) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
